// File: rtl/mux_gate_selftest.sv
// mux_gate_selftest: truth-table self-test sequencer for the mux gate block; MUX_GATE_FIRST_FAIL_LOG_EN adds first-failure capture
module mux_gate_selftest #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             output_and,
    input  logic             output_or,
    input  logic             output_not,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [2:0]       first_fail_gates
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;
    state_t           r_state, w_state_next;
    logic [1:0]       r_idx;
    logic [3:0]       r_pass_idx, r_settle;
    logic [2:0]       w_mis;
    logic [ERR_W+1:0] w_sum;
    logic [ERR_W-1:0] w_err_next;
    logic             w_last, w_accept;

    // two guard bits let the sum of up to three mismatches be checked for overflow
    always_comb begin
        w_mis      = {output_not ^ ~a, output_or ^ (a | b), output_and ^ (a & b)};
        w_sum      = {2'b00, err_count} + (ERR_W+2)'(w_mis[0]) + (ERR_W+2)'(w_mis[1]) + (ERR_W+2)'(w_mis[2]);
        w_err_next = (w_sum[ERR_W+1:ERR_W] != 2'b00) ? '1 : w_sum[ERR_W-1:0];
        w_last     = (r_idx == 2'd3) && (r_pass_idx == 4'(NUM_PASSES - 1));
        w_accept   = (r_state == S_IDLE) && start;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = start ? S_APPLY : S_IDLE;
            S_APPLY:  w_state_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
            S_SETTLE: w_state_next = (r_settle == 4'(SETTLE_CYCLES - 1)) ? S_CHECK : S_SETTLE;
            S_CHECK:  w_state_next = w_last ? S_DONE : S_APPLY;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // done and pass land together on the edge into DONE, so pass already includes the final check
    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            r_idx      <= '0;
            r_pass_idx <= '0;
            r_settle   <= '0;
        end else begin
            busy <= (w_state_next != S_IDLE);
            done <= (w_state_next == S_DONE);
            if (w_accept) begin
                err_count  <= '0;
                pass       <= 1'b0;
                r_idx      <= '0;
                r_pass_idx <= '0;
            end
            if (r_state == S_APPLY) begin
                a        <= r_idx[1];
                b        <= r_idx[0];
                r_settle <= '0;
            end
            if (r_state == S_SETTLE) r_settle <= r_settle + 4'd1;
            if (r_state == S_CHECK) begin
                err_count <= w_err_next;
                r_idx     <= r_idx + 2'd1;
                if (r_idx == 2'd3) r_pass_idx <= r_pass_idx + 4'd1;
                if (w_last) pass <= (w_err_next == '0);
            end
            if (r_state == S_DONE || r_state == S_IDLE) begin
                a <= 1'b0;
                b <= 1'b0;
            end
        end
    end

`ifdef MUX_GATE_FIRST_FAIL_LOG_EN
    logic [1:0] r_ff_vec;
    logic [2:0] r_ff_gates;

    // a nonzero gate mask doubles as the "already captured" flag
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_ff_vec   <= '0;
            r_ff_gates <= '0;
        end else if (r_state == S_CHECK && r_ff_gates == 3'b000 && w_mis != 3'b000) begin
            r_ff_vec   <= {a, b};
            r_ff_gates <= w_mis;
        end
    end

    assign first_fail_vec   = r_ff_vec;
    assign first_fail_gates = r_ff_gates;
`else
    assign first_fail_vec   = '0;
    assign first_fail_gates = '0;
`endif
endmodule

// File: tb/tb_mux_gate_selftest.sv
// tb_mux_gate_selftest: drives two self-test instances against a fault-injectable gate model
module tb_mux_gate_selftest;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] f_and = 2'd0, f_or = 2'd0, f_not = 2'd0;
    logic a_m, b_m, busy_m, done_m, pass_m, and_m, or_m, not_m;
    logic [7:0] err_m;
    logic [1:0] fv_m;
    logic [2:0] fg_m;
    logic a_x, b_x, busy_x, done_x, pass_x, and_x, or_x, not_x;
    logic [3:0] err_x;
    logic [1:0] fv_x;
    logic [2:0] fg_x;
    int checks = 0, errors = 0;
    logic [63:0] t_busy_m, t_done_m, t_pass_m, t_busy_x, t_done_x, t_pass_x;
    logic [1:0] t_ab_m [64];
    logic [1:0] t_ab_x [64];
    logic [7:0] t_err_m [64];
    logic [3:0] t_err_x [64];

    always #5 clk = ~clk;

    // fault modes: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
    function automatic logic flt(input logic x, input logic [1:0] m);
        return (m == 2'd0) ? x : (m == 2'd1) ? 1'b0 : (m == 2'd2) ? 1'b1 : ~x;
    endfunction

    assign and_m = flt(a_m & b_m, f_and);
    assign or_m  = flt(a_m | b_m, f_or);
    assign not_m = flt(~a_m, f_not);
    assign and_x = flt(a_x & b_x, f_and);
    assign or_x  = flt(a_x | b_x, f_or);
    assign not_x = flt(~a_x, f_not);

    mux_gate_selftest u_main (
        .clk(clk), .rst(rst), .start(start),
        .output_and(and_m), .output_or(or_m), .output_not(not_m),
        .a(a_m), .b(b_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .first_fail_vec(fv_m), .first_fail_gates(fg_m)
    );

    mux_gate_selftest #(.SETTLE_CYCLES(0), .NUM_PASSES(2), .ERR_W(4)) u_alt (
        .clk(clk), .rst(rst), .start(start),
        .output_and(and_x), .output_or(or_x), .output_not(not_x),
        .a(a_x), .b(b_x), .busy(busy_x), .done(done_x), .pass(pass_x),
        .err_count(err_x), .first_fail_vec(fv_x), .first_fail_gates(fg_x)
    );

    function automatic int model_err(input int passes, input int maxv);
        int e = 0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            e += int'(flt(vv[1] & vv[0], f_and) != (vv[1] & vv[0]));
            e += int'(flt(vv[1] | vv[0], f_or) != (vv[1] | vv[0]));
            e += int'(flt(~vv[1], f_not) != ~vv[1]);
        end
        e = e * passes;
        return (e > maxv) ? maxv : e;
    endfunction

    function automatic logic [4:0] model_first();
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            logic [2:0] g;
            vv = 2'(v);
            g = {flt(~vv[1], f_not) != ~vv[1], flt(vv[1] | vv[0], f_or) != (vv[1] | vv[0]),
                 flt(vv[1] & vv[0], f_and) != (vv[1] & vv[0])};
            if (g != 3'b000) return {vv, g};
        end
        return 5'b0;
    endfunction

    function automatic int first_one(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    // cycle k's start/rst come from bit k; observations after the edge ending cycle k land in slot k+1
    task automatic run(input logic [63:0] ss, input logic [63:0] rr, input int win);
        t_busy_m = '0; t_done_m = '0; t_pass_m = '0;
        t_busy_x = '0; t_done_x = '0; t_pass_x = '0;
        for (int k = 0; k < 64; k++) begin
            t_ab_m[k] = '0; t_ab_x[k] = '0; t_err_m[k] = '0; t_err_x[k] = '0;
        end
        for (int k = 0; k < win; k++) begin
            start = ss[k];
            rst = rr[k];
            @(posedge clk);
            #1;
            t_busy_m[k+1] = busy_m; t_done_m[k+1] = done_m; t_pass_m[k+1] = pass_m;
            t_ab_m[k+1] = {a_m, b_m}; t_err_m[k+1] = err_m;
            t_busy_x[k+1] = busy_x; t_done_x[k+1] = done_x; t_pass_x[k+1] = pass_x;
            t_ab_x[k+1] = {a_x, b_x}; t_err_x[k+1] = err_x;
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        run(64'd0, 64'hF, 3);
        checks++;
        if ({busy_m, done_m, pass_m, a_m, b_m} !== 5'b0)
            $display("FAIL reset_ctl_m: got %b want 00000", {busy_m, done_m, pass_m, a_m, b_m});
        checks++;
        if (err_m !== 8'd0) $display("FAIL reset_err_m: got %0d want 0", err_m);
        checks++;
        if ({fv_m, fg_m} !== 5'b0) $display("FAIL reset_log_m: got %b want 00000", {fv_m, fg_m});
        checks++;
        if ({busy_x, done_x, pass_x, a_x, b_x} !== 5'b0)
            $display("FAIL reset_ctl_x: got %b want 00000", {busy_x, done_x, pass_x, a_x, b_x});
        checks++;
        if (err_x !== 4'd0) $display("FAIL reset_err_x: got %0d want 0", err_x);
        checks++;
        if ({fv_x, fg_x} !== 5'b0) $display("FAIL reset_log_x: got %b want 00000", {fv_x, fg_x});
        errors += int'({busy_m, done_m, pass_m, a_m, b_m} !== 5'b0) + int'(err_m !== 8'd0)
                + int'({fv_m, fg_m} !== 5'b0) + int'({busy_x, done_x, pass_x, a_x, b_x} !== 5'b0)
                + int'(err_x !== 4'd0) + int'({fv_x, fg_x} !== 5'b0);
    endtask

    task automatic test_gate_faults(input logic [1:0] fa, input logic [1:0] fo, input logic [1:0] fn);
        logic [63:0] exp_busy;
        logic [7:0]  ab_m;
        logic [15:0] ab_x;
        logic [4:0]  ff;
        int em, ex;
        f_and = fa; f_or = fo; f_not = fn;
        run(64'd1, 64'd0, 24);
        em = model_err(1, 255);
        ex = model_err(2, 15);
        ff = model_first();
        exp_busy = '0;
        for (int k = 1; k <= 17; k++) exp_busy[k] = 1'b1;
        for (int v = 0; v < 4; v++) ab_m[2*v +: 2] = t_ab_m[2 + 4*v];
        for (int p = 0; p < 2; p++)
            for (int v = 0; v < 4; v++) ab_x[8*p + 2*v +: 2] = t_ab_x[2 + 2*v + 8*p];
        checks++;
        if (first_one(t_done_m) != 17 || $countones(t_done_m) != 1) begin
            errors++;
            $display("FAIL done_m[%0d%0d%0d]: first=%0d count=%0d want 17/1", fa, fo, fn, first_one(t_done_m), $countones(t_done_m));
        end
        checks++;
        if (first_one(t_done_x) != 17 || $countones(t_done_x) != 1) begin
            errors++;
            $display("FAIL done_x[%0d%0d%0d]: first=%0d count=%0d want 17/1", fa, fo, fn, first_one(t_done_x), $countones(t_done_x));
        end
        checks++;
        if (t_busy_m[24:0] !== exp_busy[24:0]) begin
            errors++;
            $display("FAIL busy_m: got %h want %h", t_busy_m[24:0], exp_busy[24:0]);
        end
        checks++;
        if (t_busy_x[24:0] !== exp_busy[24:0]) begin
            errors++;
            $display("FAIL busy_x: got %h want %h", t_busy_x[24:0], exp_busy[24:0]);
        end
        checks++;
        if (ab_m !== 8'he4) begin
            errors++;
            $display("FAIL ab_seq_m: got %h want e4", ab_m);
        end
        checks++;
        if (ab_x !== 16'he4e4) begin
            errors++;
            $display("FAIL ab_seq_x: got %h want e4e4", ab_x);
        end
        checks++;
        if (t_err_m[17] !== 8'(em) || t_pass_m[17] !== (em == 0)) begin
            errors++;
            $display("FAIL result_m[%0d%0d%0d]: err=%0d pass=%b want err=%0d pass=%b", fa, fo, fn, t_err_m[17], t_pass_m[17], em, em == 0);
        end
        checks++;
        if (t_err_x[17] !== 4'(ex) || t_pass_x[17] !== (ex == 0)) begin
            errors++;
            $display("FAIL result_x[%0d%0d%0d]: err=%0d pass=%b want err=%0d pass=%b", fa, fo, fn, t_err_x[17], t_pass_x[17], ex, ex == 0);
        end
        checks++;
        if (t_err_m[24] !== 8'(em) || t_pass_m[24] !== (em == 0)) begin
            errors++;
            $display("FAIL hold_m: err=%0d pass=%b want err=%0d pass=%b", t_err_m[24], t_pass_m[24], em, em == 0);
        end
`ifndef MUX_GATE_FIRST_FAIL_LOG_EN
        ff = 5'b0;
`endif
        checks++;
        if ({fv_m, fg_m} !== ff || {fv_x, fg_x} !== ff) begin
            errors++;
            $display("FAIL first_fail: got m=%b x=%b want %b", {fv_m, fg_m}, {fv_x, fg_x}, ff);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            test_gate_faults(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    task automatic test_mid_run_reset();
        f_and = 2'd0; f_or = 2'd1; f_not = 2'd0;
        run(64'd1, 64'd1 << 10, 40);
        checks++;
        if (t_ab_m[10] !== 2'b10 || t_err_m[10] !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset: ab=%b err=%0d want ab=10 err=1", t_ab_m[10], t_err_m[10]);
        end
        checks++;
        if ({t_busy_m[11], t_pass_m[11], t_ab_m[11]} !== 4'b0 || t_err_m[11] !== 8'd0) begin
            errors++;
            $display("FAIL abort_m: busy=%b pass=%b ab=%b err=%0d want all 0", t_busy_m[11], t_pass_m[11], t_ab_m[11], t_err_m[11]);
        end
        checks++;
        if ({t_busy_x[11], t_pass_x[11], t_ab_x[11]} !== 4'b0 || t_err_x[11] !== 4'd0) begin
            errors++;
            $display("FAIL abort_x: busy=%b pass=%b ab=%b err=%0d want all 0", t_busy_x[11], t_pass_x[11], t_ab_x[11], t_err_x[11]);
        end
        checks++;
        if ((t_done_m | t_done_x) !== 64'd0) begin
            errors++;
            $display("FAIL abort_no_done: got m=%h x=%h want 0", t_done_m, t_done_x);
        end
    endtask

    task automatic test_start_ignored();
        f_and = 2'd0; f_or = 2'd1; f_not = 2'd0;
        run(64'd1 | (64'd1 << 5) | (64'd1 << 17) | (64'd1 << 18), 64'd0, 45);
        checks++;
        if (t_done_m[45:0] !== 46'((64'd1 << 17) | (64'd1 << 35))) begin
            errors++;
            $display("FAIL ignore_done_m: got %h want dones at 17,35", t_done_m[45:0]);
        end
        checks++;
        if (t_done_x[45:0] !== 46'((64'd1 << 17) | (64'd1 << 35))) begin
            errors++;
            $display("FAIL ignore_done_x: got %h want dones at 17,35", t_done_x[45:0]);
        end
        checks++;
        if (t_err_m[18] !== 8'd3 || t_busy_m[18] !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap: err=%0d busy=%b want 3/0", t_err_m[18], t_busy_m[18]);
        end
        checks++;
        if (t_err_m[19] !== 8'd0 || t_busy_m[19] !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear: err=%0d busy=%b want 0/1", t_err_m[19], t_busy_m[19]);
        end
        checks++;
        if (t_err_m[36] !== 8'd3 || t_pass_m[36] !== 1'b0) begin
            errors++;
            $display("FAIL second_run: err=%0d pass=%b want 3/0", t_err_m[36], t_pass_m[36]);
        end
    endtask

    task automatic test_start_held();
        f_and = 2'd0; f_or = 2'd0; f_not = 2'd0;
        run('1, 64'd0, 45);
        checks++;
        if (t_done_m[45:0] !== 46'((64'd1 << 17) | (64'd1 << 35))) begin
            errors++;
            $display("FAIL held_done: got %h want dones at 17,35", t_done_m[45:0]);
        end
        checks++;
        if ({t_pass_m[17], t_pass_m[18], t_pass_m[19], t_pass_m[35]} !== 4'b1101) begin
            errors++;
            $display("FAIL held_pass: got %b want 1101", {t_pass_m[17], t_pass_m[18], t_pass_m[19], t_pass_m[35]});
        end
        checks++;
        if ({t_busy_m[18], t_ab_m[18]} !== 3'b000 || t_busy_m[19] !== 1'b1) begin
            errors++;
            $display("FAIL held_gap: busy18=%b ab18=%b busy19=%b want 0/00/1", t_busy_m[18], t_ab_m[18], t_busy_m[19]);
        end
        run(64'd0, 64'd0, 30);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_gate_faults(2'd0, 2'd0, 2'd0);
        test_gate_faults(2'd0, 2'd1, 2'd0);
        test_gate_faults(2'd0, 2'd0, 2'd3);
        test_gate_faults(2'd3, 2'd3, 2'd3);
        test_random();
        test_mid_run_reset();
        test_start_ignored();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
